// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//
// Contents:
//   state_t    - two-state FSM encoding (IDLE / GRANT)
//   clog2      - ceiling log2 helper for sizing counters at elaboration time
//   hold_width - width of a counter that must reach max_hold-1 (never below 1)
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Sized from max_hold+1 so the counter can hold max_hold itself with a bit
  // to spare. A disabled timeout (max_hold == 0) still gets a 1-bit counter
  // so the declarations stay legal.
  function automatic int hold_width(input int max_hold);
    int w;
    w = clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/decoder_n_to_m.sv
// Binary-to-one-hot decoder with enable.
//
// Ports:
//   sel    [N-1:0]  binary select index
//   enable          when low the output is all zero
//   onehot [M-1:0]  one-hot decode of sel, gated by enable
module decoder_n_to_m #(
  parameter int N = 3,
  parameter int M = 8
) (
  input  logic [N-1:0] sel,
  input  logic         enable,
  output logic [M-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters.
//
// The winner is picked by a circular scan starting at a rotating pointer,
// registered into grant_idx, and turned into a one-hot grant by the decoder.
// A hold timer forces release after MAX_HOLD consecutive grant cycles
// (MAX_HOLD = 0 disables it). Every grant is followed by one idle cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   req            [NUM_REQ-1:0] level requests, held until served
//   release_grant  owner is done; only looked at while granting
//                  (named this way because "release" is a reserved word)
//   grant          [NUM_REQ-1:0] one-hot grant, zero when not valid
//   grant_valid    resource currently owned
//   grant_idx      [IDX_W-1:0] owner index, keeps last value when idle
//   timeout        one-cycle pulse when the hold timer ended a grant
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int IDX_W    = 3,
  parameter int NUM_REQ  = 2 ** IDX_W,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               release_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout
);

  localparam int HOLD_W        = hold_width(MAX_HOLD);
  localparam int HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_INT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   idx_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic               timeout_n;

  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   cand;

  logic               end_release;
  logic               end_withdraw;
  logic               end_force;

  // Circular priority scan: walk offsets from the highest down to zero so
  // the smallest offset from ptr that has a request is the last one written.
  // The index adder wraps naturally because NUM_REQ == 2**IDX_W.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  assign end_release  = release_grant;
  assign end_withdraw = ~req[grant_idx];
  assign end_force    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    idx_n      = grant_idx;
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (scan_found) begin
          idx_n      = scan_idx;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end
      end

      GRANT: begin
        if (end_release || end_withdraw || end_force) begin
          state_n   = IDLE;
          ptr_n     = grant_idx + 1'b1;
          // Only flag a timeout when the owner was actually cut off; if it
          // was leaving anyway on this edge the timer did not matter.
          timeout_n = end_force && !end_release && !end_withdraw;
        end else if (MAX_HOLD != 0) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= idx_n;
      hold_cnt  <= hold_cnt_n;
      timeout   <= timeout_n;
    end
  end

  assign grant_valid = (state == GRANT);

  decoder_n_to_m #(
    .N(IDX_W),
    .M(NUM_REQ)
  ) u_grant_decoder (
    .sel   (grant_idx),
    .enable(grant_valid),
    .onehot(grant)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter (built with MAX_HOLD = 4 so the
// hold timer is reached quickly). Each step drives inputs on the falling
// edge, pushes the expected post-edge outputs to a scoreboard queue, and
// pops/compares them just after the rising edge.
module tb_rr_decoder_arbiter;

  localparam int IDX_W    = 3;
  localparam int NUM_REQ  = 8;
  localparam int MAX_HOLD = 4;

  typedef struct {
    string           tag;
    logic            valid;
    logic [IDX_W-1:0] idx;
    logic            tmo;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic               release_grant;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               timeout;

  exp_t exp_q[$];
  int   num_checks;
  int   num_errors;

  rr_decoder_arbiter #(
    .IDX_W   (IDX_W),
    .NUM_REQ (NUM_REQ),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .release_grant(release_grant),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks = num_checks + 1;
    if (observed !== expected) begin
      num_errors = num_errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and the outputs expected right after the edge.
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic [NUM_REQ-1:0] r, input logic rel,
                               input logic ev, input int eidx, input logic et);
    exp_t e;
    exp_t got;
    logic [NUM_REQ-1:0] egrant;
    @(negedge clk);
    reset         = rst;
    req           = r;
    release_grant = rel;
    e.tag   = tag;
    e.valid = ev;
    e.idx   = IDX_W'(eidx);
    e.tmo   = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got    = exp_q.pop_front();
      egrant = got.valid ? (NUM_REQ'(1) << got.idx) : '0;
      checkOutput({got.tag, "_grant"}, 32'(grant), 32'(egrant));
      checkOutput({got.tag, "_valid"}, 32'(grant_valid), 32'(got.valid));
      checkOutput({got.tag, "_idx"}, 32'(grant_idx), 32'(got.idx));
      checkOutput({got.tag, "_timeout"}, 32'(timeout), 32'(got.tmo));
    end
  endtask

  initial begin
    num_checks    = 0;
    num_errors    = 0;
    reset         = 1'b1;
    req           = '0;
    release_grant = 1'b0;

    // Reset state
    applyStimulus("reset", 1, 8'h00, 0, 0, 0, 0);
    applyStimulus("reset2", 1, 8'hFF, 1, 0, 0, 0);

    // Single requester, released in its 3rd grant cycle
    applyStimulus("single_g1", 0, 8'h04, 0, 1, 2, 0);
    applyStimulus("single_g2", 0, 8'h04, 0, 1, 2, 0);
    applyStimulus("single_g3", 0, 8'h04, 0, 1, 2, 0);
    applyStimulus("single_end", 0, 8'h04, 1, 0, 2, 0);
    applyStimulus("single_idle", 0, 8'h00, 0, 0, 2, 0);
    // ptr should now be 3: with bits 0,2,3 requesting, 3 wins
    applyStimulus("ptr3_g", 0, 8'h0D, 0, 1, 3, 0);
    applyStimulus("ptr3_end", 0, 8'h0D, 1, 0, 3, 0);
    // ptr 4: nothing in 4..7, scan wraps to 0
    applyStimulus("wrap_scan_g", 0, 8'h0D, 0, 1, 0, 0);
    applyStimulus("wrap_scan_end", 0, 8'h0D, 1, 0, 0, 0);

    // Fairness: all requesting, release held high (ignored while idle)
    applyStimulus("fair_reset", 1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < NUM_REQ; k++) begin
      applyStimulus($sformatf("fair_g%0d", k), 0, 8'hFF, 1, 1, k, 0);
      applyStimulus($sformatf("fair_bub%0d", k), 0, 8'hFF, 1, 0, k, 0);
    end

    // Wrap-around after index 7: 0 before 7, then 7
    applyStimulus("wrap_g0", 0, 8'h81, 0, 1, 0, 0);
    applyStimulus("wrap_end0", 0, 8'h81, 1, 0, 0, 0);
    applyStimulus("wrap_g7", 0, 8'h81, 0, 1, 7, 0);
    applyStimulus("wrap_end7", 0, 8'h81, 1, 0, 7, 0);

    // Hold timer: exactly MAX_HOLD grant cycles, then timeout in the bubble
    applyStimulus("tmo_reset", 1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < MAX_HOLD; k++) begin
      applyStimulus($sformatf("tmo_g%0d", k), 0, 8'h10, 0, 1, 4, 0);
    end
    applyStimulus("tmo_pulse", 0, 8'h10, 0, 0, 4, 1);
    applyStimulus("tmo_regrant", 0, 8'h10, 0, 1, 4, 0);
    // Release coinciding with the limit: no timeout
    for (int k = 1; k < MAX_HOLD; k++) begin
      applyStimulus($sformatf("tmo2_g%0d", k), 0, 8'h10, 0, 1, 4, 0);
    end
    applyStimulus("tmo_rel_coincide", 0, 8'h10, 1, 0, 4, 0);

    // Withdrawal mid-grant; other req bits ignored while granting
    applyStimulus("wd_reset", 1, 8'h00, 0, 0, 0, 0);
    applyStimulus("wd_g1", 0, 8'h02, 0, 1, 1, 0);
    applyStimulus("wd_other", 0, 8'hF3, 0, 1, 1, 0);
    applyStimulus("wd_drop", 0, 8'h00, 0, 0, 1, 0);
    applyStimulus("wd_next", 0, 8'h06, 0, 1, 2, 0);
    applyStimulus("wd_next_end", 0, 8'h06, 1, 0, 2, 0);

    // Reset mid-grant
    applyStimulus("rst_reset", 1, 8'h00, 0, 0, 0, 0);
    applyStimulus("rst_g5", 0, 8'h20, 0, 1, 5, 0);
    applyStimulus("rst_mid", 1, 8'h20, 0, 0, 0, 0);
    applyStimulus("rst_after", 0, 8'h22, 0, 1, 1, 0);
    applyStimulus("rst_after_end", 0, 8'h22, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
